// File: rtl/id_stage_hs_pkg.sv
// Shared ISA definitions for the decode stage: default widths, opcode encodings,
// the canonical NOP word, the decode FSM states and the 16-bit sign-extension helper.
package id_stage_hs_pkg;

  localparam int unsigned IsaWidth      = 32;
  localparam int unsigned IsaRegAddrLen = 5;

  typedef enum logic [5:0] {
    OpNop    = 6'h00,
    OpRType  = 6'h01,
    OpIType  = 6'h02,
    OpLw     = 6'h03,
    OpLh     = 6'h04,
    OpLd     = 6'h05,
    OpSw     = 6'h06,
    OpSh     = 6'h07,
    OpSd     = 6'h08,
    OpBranch = 6'h09,
    OpJType  = 6'h0A,
    OpHalt   = 6'h3F
  } opcode_e;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StHold = 2'd2
  } id_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_operand_port.sv
// One register-operand port of the decode stage.
// Holds the pending flag, the registered read address/enable and the captured operand.
// A bypass hit (lowest index wins) is taken in the accept cycle and in every pending
// cycle, and always beats a strobe arriving in the same cycle.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  drop any pending request
//   load, load_addr        accept-cycle request for register load_addr
//   byp_valid/addr/data    packed forwarding sources
//   rd_data, rd_st         register-file response
//   rd_en, rd_addr         register-file request (registered)
//   data                   captured operand
//   pending_next           pending flag as it will be after the next edge
module id_operand_port
  import id_stage_hs_pkg::*;
#(
  parameter int unsigned WIDTH        = IsaWidth,
  parameter int unsigned REG_ADDR_LEN = IsaRegAddrLen,
  parameter int unsigned NUM_BYP      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            load,
  input  logic [REG_ADDR_LEN-1:0]         load_addr,
  input  logic [NUM_BYP-1:0]              byp_valid,
  input  logic [NUM_BYP*REG_ADDR_LEN-1:0] byp_addr,
  input  logic [NUM_BYP*WIDTH-1:0]        byp_data,
  input  logic [WIDTH-1:0]                rd_data,
  input  logic                            rd_st,
  output logic                            rd_en,
  output logic [REG_ADDR_LEN-1:0]         rd_addr,
  output logic [WIDTH-1:0]                data,
  output logic                            pending_next
);

  logic                    pending_q, pending_d;
  logic [REG_ADDR_LEN-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [REG_ADDR_LEN-1:0] match_addr;
  logic                    byp_hit;
  logic [WIDTH-1:0]        byp_val;

  // Priority mux: scan from the highest index down so the lowest match is left standing.
  always_comb begin
    match_addr = load ? load_addr : addr_q;
    byp_hit    = 1'b0;
    byp_val    = '0;
    for (int i = int'(NUM_BYP) - 1; i >= 0; i--) begin
      if (byp_valid[i] && (match_addr != '0) &&
          (byp_addr[i*REG_ADDR_LEN +: REG_ADDR_LEN] == match_addr)) begin
        byp_hit = 1'b1;
        byp_val = byp_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (flush) begin
      pending_d = 1'b0;
    end else if (load) begin
      addr_d = load_addr;
      if (load_addr == '0) begin
        // r0 is hardwired to zero and never requested.
        data_d    = '0;
        pending_d = 1'b0;
      end else if (byp_hit) begin
        data_d    = byp_val;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (pending_q) begin
      if (byp_hit) begin
        data_d    = byp_val;
        pending_d = 1'b0;
      end else if (rd_st) begin
        data_d    = rd_data;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // The request enable is the pending flag itself, so a strobe with en low is never taken.
  assign rd_en        = pending_q;
  assign rd_addr      = addr_q;
  assign data         = data_q;
  assign pending_next = pending_d;

endmodule

// File: rtl/id_stage_hs.sv
// Clocked valid/ready decode stage between IF and EX.
// Accepts one instruction, decodes its operand sources, fetches up to two registers over
// the en/st register-file handshake (with write-back bypass), and holds a registered
// {IR, PC, X, Y} bundle for EX until out_ready. flush returns the stage to idle.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid, in_ready, ir_in, pc_in    IF side
//   out_valid, out_ready, ir_out,
//   pc_out, x_out, y_out                EX side
//   rd{1,2}_addr/en/data/st             register-file read ports
//   byp_valid/addr/data                 forwarding sources, index 0 highest priority
//   flush                               discard the in-flight instruction
module id_stage_hs
  import id_stage_hs_pkg::*;
#(
  parameter int unsigned WIDTH        = IsaWidth,
  parameter int unsigned PC_W         = WIDTH - 2,
  parameter int unsigned REG_ADDR_LEN = IsaRegAddrLen,
  parameter int unsigned NUM_BYP      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                ir_in,
  input  logic [PC_W-1:0]                 pc_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                ir_out,
  output logic [PC_W-1:0]                 pc_out,
  output logic [WIDTH-1:0]                x_out,
  output logic [WIDTH-1:0]                y_out,
  output logic [REG_ADDR_LEN-1:0]         rd1_addr,
  output logic                            rd1_en,
  input  logic [WIDTH-1:0]                rd1_data,
  input  logic                            rd1_st,
  output logic [REG_ADDR_LEN-1:0]         rd2_addr,
  output logic                            rd2_en,
  input  logic [WIDTH-1:0]                rd2_data,
  input  logic                            rd2_st,
  input  logic [NUM_BYP-1:0]              byp_valid,
  input  logic [NUM_BYP*REG_ADDR_LEN-1:0] byp_addr,
  input  logic [NUM_BYP*WIDTH-1:0]        byp_data,
  input  logic                            flush
);

  id_state_e state_q, state_d;

  logic [WIDTH-1:0] ir_q;
  logic [PC_W-1:0]  pc_q;
  logic [WIDTH-1:0] x_imm_q, x_imm_d;
  logic [WIDTH-1:0] y_imm_q, y_imm_d;
  logic             x_use_q, y_use_q;

  logic                    accept;
  logic                    use1_d, use2_d;
  logic [REG_ADDR_LEN-1:0] addr1_d, addr2_d;
  logic [REG_ADDR_LEN-1:0] f_rd, f_rs, f_rt;
  logic [WIDTH-1:0]        p1_data, p2_data;
  logic                    p1_next, p2_next;

  assign accept = (state_q == StIdle) && in_valid && !flush;

  assign f_rd = REG_ADDR_LEN'(ir_in[25:21]);
  assign f_rs = REG_ADDR_LEN'(ir_in[20:16]);
  assign f_rt = REG_ADDR_LEN'(ir_in[15:11]);

  // Port 1 always feeds X, port 2 always feeds Y; otherwise the operand is an immediate.
  always_comb begin
    use1_d  = 1'b0;
    use2_d  = 1'b0;
    addr1_d = '0;
    addr2_d = '0;
    x_imm_d = '0;
    y_imm_d = '0;
    case (ir_in[31:26])
      OpRType: begin
        use1_d  = 1'b1;
        addr1_d = f_rs;
        use2_d  = 1'b1;
        addr2_d = f_rt;
      end
      OpIType, OpLw, OpLh, OpLd: begin
        use1_d  = 1'b1;
        addr1_d = f_rs;
        y_imm_d = WIDTH'($signed(sext16(ir_in[15:0])));
      end
      OpBranch: begin
        use1_d  = 1'b1;
        addr1_d = f_rd;
        y_imm_d = WIDTH'($signed(sext16(ir_in[15:0])));
      end
      OpSw, OpSh, OpSd: begin
        use1_d  = 1'b1;
        addr1_d = f_rd;
        use2_d  = 1'b1;
        addr2_d = f_rs;
      end
      OpJType: begin
        x_imm_d = WIDTH'(ir_in[25:0]);
      end
      default: ;
    endcase
  end

  id_operand_port #(
    .WIDTH        (WIDTH),
    .REG_ADDR_LEN (REG_ADDR_LEN),
    .NUM_BYP      (NUM_BYP)
  ) u_port1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .load         (accept && use1_d),
    .load_addr    (addr1_d),
    .byp_valid    (byp_valid),
    .byp_addr     (byp_addr),
    .byp_data     (byp_data),
    .rd_data      (rd1_data),
    .rd_st        (rd1_st),
    .rd_en        (rd1_en),
    .rd_addr      (rd1_addr),
    .data         (p1_data),
    .pending_next (p1_next)
  );

  id_operand_port #(
    .WIDTH        (WIDTH),
    .REG_ADDR_LEN (REG_ADDR_LEN),
    .NUM_BYP      (NUM_BYP)
  ) u_port2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .load         (accept && use2_d),
    .load_addr    (addr2_d),
    .byp_valid    (byp_valid),
    .byp_addr     (byp_addr),
    .byp_data     (byp_data),
    .rd_data      (rd2_data),
    .rd_st        (rd2_st),
    .rd_en        (rd2_en),
    .rd_addr      (rd2_addr),
    .data         (p2_data),
    .pending_next (p2_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (p1_next || p2_next) ? StRead : StHold;
        end
      end
      StRead: begin
        if (!p1_next && !p2_next) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= WIDTH'(NopInstr);
      pc_q    <= '0;
      x_imm_q <= '0;
      y_imm_q <= '0;
      x_use_q <= 1'b0;
      y_use_q <= 1'b0;
    end else if (flush) begin
      ir_q <= WIDTH'(NopInstr);
    end else if (accept) begin
      ir_q    <= ir_in;
      pc_q    <= pc_in;
      x_imm_q <= x_imm_d;
      y_imm_q <= y_imm_d;
      x_use_q <= use1_d;
      y_use_q <= use2_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign x_out     = x_use_q ? p1_data : x_imm_q;
  assign y_out     = y_use_q ? p2_data : y_imm_q;

endmodule

// File: tb/tb_id_stage_hs.sv
module tb_id_stage_hs;
  import id_stage_hs_pkg::*;

  localparam int W  = 32;
  localparam int PW = 30;
  localparam int RA = 5;
  localparam int NB = 2;

  logic            clk, rst_n;
  logic            in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0]    ir_in, ir_out, x_out, y_out;
  logic [PW-1:0]   pc_in, pc_out;
  logic [RA-1:0]   rd1_addr, rd2_addr;
  logic            rd1_en, rd2_en, rd1_st, rd2_st;
  logic [W-1:0]    rd1_data, rd2_data;
  logic [NB-1:0]   byp_valid;
  logic [NB*RA-1:0] byp_addr;
  logic [NB*W-1:0] byp_data;

  id_stage_hs #(
    .WIDTH        (W),
    .PC_W         (PW),
    .REG_ADDR_LEN (RA),
    .NUM_BYP      (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir_in     (ir_in),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ir_out    (ir_out),
    .pc_out    (pc_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .rd1_addr  (rd1_addr),
    .rd1_en    (rd1_en),
    .rd1_data  (rd1_data),
    .rd1_st    (rd1_st),
    .rd2_addr  (rd2_addr),
    .rd2_en    (rd2_en),
    .rd2_data  (rd2_data),
    .rd2_st    (rd2_st),
    .byp_valid (byp_valid),
    .byp_addr  (byp_addr),
    .byp_data  (byp_data),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] regs [32];
  int          lat1 = 1, lat2 = 1;
  bit          rf_on = 1'b1;
  logic        rsp_st1 = 1'b0, rsp_st2 = 1'b0, man_st1 = 1'b0, man_st2 = 1'b0;
  logic [31:0] rsp_d1 = '0, rsp_d2 = '0, man_d1 = '0, man_d2 = '0;
  int          en_tot1 = 0, en_tot2 = 0;

  assign rd1_st   = rf_on ? rsp_st1 : man_st1;
  assign rd2_st   = rf_on ? rsp_st2 : man_st2;
  assign rd1_data = rf_on ? rsp_d1 : man_d1;
  assign rd2_data = rf_on ? rsp_d2 : man_d2;

  // Register-file responders: strobe lat cycles after en is first seen.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rd1_en === 1'b1) begin
        cnt++;
        rsp_st1 = (cnt >= lat1);
        rsp_d1  = rsp_st1 ? regs[rd1_addr] : $urandom;
      end else begin
        cnt = 0;
        rsp_st1 = 1'b0;
        rsp_d1  = $urandom;
      end
    end
  end

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rd2_en === 1'b1) begin
        cnt++;
        rsp_st2 = (cnt >= lat2);
        rsp_d2  = rsp_st2 ? regs[rd2_addr] : $urandom;
      end else begin
        cnt = 0;
        rsp_st2 = 1'b0;
        rsp_d2  = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rd1_en === 1'b1) en_tot1++;
      if (rd2_en === 1'b1) en_tot2++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bhit(input logic [4:0] a);
    for (int i = 0; i < NB; i++)
      if (byp_valid[i] && byp_addr[i*RA +: RA] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Architectural value of a register as seen by decode.
  function automatic logic [31:0] rval(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < NB; i++)
      if (byp_valid[i] && byp_addr[i*RA +: RA] == a) return byp_data[i*W +: W];
    return regs[a];
  endfunction

  task automatic model(input logic [31:0] ir, output logic [31:0] ex, output logic [31:0] ey,
                       output bit n1, output bit n2);
    logic [5:0]  op;
    logic [31:0] sx;
    bit          xr, yr;
    logic [4:0]  xa, ya;
    op = ir[31:26];
    sx = {{16{ir[15]}}, ir[15:0]};
    xr = 0; yr = 0; xa = 0; ya = 0; ex = 0; ey = 0;
    case (op)
      OpRType:               begin xr = 1; xa = ir[20:16]; yr = 1; ya = ir[15:11]; end
      OpIType, OpLw, OpLh, OpLd: begin xr = 1; xa = ir[20:16]; ey = sx; end
      OpBranch:              begin xr = 1; xa = ir[25:21]; ey = sx; end
      OpSw, OpSh, OpSd:      begin xr = 1; xa = ir[25:21]; yr = 1; ya = ir[20:16]; end
      OpJType:               ex = {6'b0, ir[25:0]};
      default: ;
    endcase
    if (xr) ex = rval(xa);
    if (yr) ey = rval(ya);
    n1 = xr && (xa != 0) && !bhit(xa);
    n2 = yr && (ya != 0) && !bhit(ya);
  endtask

  task automatic do_txn(input logic [31:0] ir, input logic [29:0] pc, input int l1,
                        input int l2, input string tag);
    logic [31:0] ex, ey;
    bit          n1, n2;
    int          b1, b2, n, exp_lat;
    model(ir, ex, ey, n1, n2);
    lat1 = l1; lat2 = l2; rf_on = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; ir_in = ir; pc_in = pc;
    b1 = en_tot1; b2 = en_tot2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    exp_lat = 1;
    if (n1 && l1 + 1 > exp_lat) exp_lat = l1 + 1;
    if (n2 && l2 + 1 > exp_lat) exp_lat = l2 + 1;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " x"}, x_out, ex);
    chk({tag, " y"}, y_out, ey);
    chk({tag, " ir"}, ir_out, ir);
    chk({tag, " pc"}, pc_out, pc);
    chk({tag, " en1 used"}, (en_tot1 - b1) > 0, n1);
    chk({tag, " en2 used"}, (en_tot2 - b2) > 0, n2);
    chk({tag, " en low"}, {rd1_en, rd2_en}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [12];

  initial begin
    ops = '{OpNop, OpRType, OpIType, OpLw, OpLh, OpLd, OpSw, OpSh, OpSd, OpBranch, OpJType,
            6'h2A};
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    rst_n = 1'b0; in_valid = 1'b0; ir_in = '0; pc_in = '0; out_ready = 1'b1; flush = 1'b0;
    byp_valid = '0; byp_addr = '0; byp_data = '0;

    // Reset values
    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst en", {rd1_en, rd2_en}, 2'b00);
    chk("rst addr", {rd1_addr, rd2_addr}, 10'h0);
    chk("rst ir_out", ir_out, 32'h0);
    chk("rst pc_out", pc_out, 0);
    chk("rst xy", {x_out, y_out}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // R_TYPE rs=3 rt=4, both strobes two cycles after en
    regs[3] = 32'hCAFE_0003;
    regs[4] = 32'hBEEF_0004;
    do_txn({OpRType, 5'd1, 5'd3, 5'd4, 11'd0}, 30'h100, 2, 2, "rtype");

    // I_TYPE satisfied by bypass in the accept cycle
    byp_valid = 2'b10;
    byp_addr  = {5'd5, 5'd0};
    byp_data  = {32'h0000_1234, 32'h0};
    do_txn({OpIType, 5'd2, 5'd5, 16'hFFF0}, 30'h104, 1, 1, "ibyp");
    byp_valid = '0;

    // Both bypass entries and a strobe land together on the pending port
    rf_on = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; ir_in = {OpIType, 5'd2, 5'd7, 16'h0010}; pc_in = 30'h108;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("prio en1", rd1_en, 1);
    chk("prio addr1", rd1_addr, 5'd7);
    byp_valid = 2'b11;
    byp_addr  = {5'd7, 5'd7};
    byp_data  = {32'hB, 32'hA};
    man_st1 = 1'b1; man_d1 = 32'hDEAD_0007;
    @(posedge clk);
    #1;
    byp_valid = '0; man_st1 = 1'b0;
    @(negedge clk);
    chk("prio out_valid", out_valid, 1);
    chk("prio x", x_out, 32'hA);
    chk("prio y", y_out, 32'h10);
    @(posedge clk);
    #1;

    // J_TYPE with EX stalling for three cycles
    out_ready = 1'b0;
    do_txn({OpJType, 26'h3FF_FFFF}, 30'h10C, 1, 1, "jump");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
      chk("stall xy", {x_out, y_out}, {32'h03FF_FFFF, 32'h0});
      chk("stall ir", ir_out, {OpJType, 26'h3FF_FFFF});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release in_ready", in_ready, 1);
    chk("release out_valid", out_valid, 0);

    // Flush during READ, strobes arrive one cycle late
    rf_on = 1'b0;
    in_valid = 1'b1; ir_in = {OpRType, 5'd1, 5'd3, 5'd4, 11'd0}; pc_in = 30'h110;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush en1 before", rd1_en, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    man_st1 = 1'b1; man_st2 = 1'b1; man_d1 = 32'h5555; man_d2 = 32'h6666;
    @(negedge clk);
    chk("flush out_valid", out_valid, 0);
    chk("flush ir", ir_out, 32'h0);
    chk("flush in_ready", in_ready, 1);
    chk("flush en", {rd1_en, rd2_en}, 2'b00);
    @(posedge clk);
    #1;
    man_st1 = 1'b0; man_st2 = 1'b0;
    @(negedge clk);
    chk("late st out_valid", out_valid, 0);
    chk("late st in_ready", in_ready, 1);

    // in_valid together with flush is not accepted
    in_valid = 1'b1; flush = 1'b1; ir_in = {OpJType, 26'h123}; pc_in = 30'h114;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+valid in_ready", in_ready, 1);
    chk("flush+valid out_valid", out_valid, 0);
    chk("flush+valid ir", ir_out, 32'h0);

    // Asynchronous reset mid-READ
    in_valid = 1'b1; ir_in = {OpRType, 5'd1, 5'd3, 5'd4, 11'd0}; pc_in = 30'h118;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("arst en1 before", rd1_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst en", {rd1_en, rd2_en}, 2'b00);
    chk("arst out_valid", out_valid, 0);
    chk("arst in_ready", in_ready, 1);
    chk("arst ir", ir_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    regs[6] = 32'h0600_0006;
    do_txn({OpLw, 5'd2, 5'd6, 16'h8001}, 30'h11C, 1, 1, "after arst");

    // Randomised transactions against the reference model
    for (int t = 0; t < 24; t++) begin
      logic [31:0] ir;
      ir = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
      byp_valid = 2'($urandom_range(0, 3));
      byp_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      byp_data  = {32'($urandom), 32'($urandom)};
      do_txn(ir, 30'($urandom), $urandom_range(1, 3), $urandom_range(1, 3), "rand");
    end
    byp_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
